// File: rtl/manycore_ep_mem_responder.sv
// Manycore link memory responder: executes load/store/swap requests against a
// local word SRAM and returns in-order responses through a 2-entry FIFO.
module manycore_ep_mem_responder #(
  parameter int unsigned data_width_p   = 32,
  parameter int unsigned addr_width_p   = 28,
  parameter int unsigned x_cord_width_p = 7,
  parameter int unsigned y_cord_width_p = 7,
  parameter int unsigned els_p          = 1024,
  parameter int unsigned reg_id_width_p = 5
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      req_v_i,
  output logic                      req_ready_o,
  input  logic [1:0]                req_op_i,
  input  logic [addr_width_p-1:0]   req_addr_i,
  input  logic [data_width_p-1:0]   req_data_i,
  input  logic [data_width_p/8-1:0] req_mask_i,
  input  logic [x_cord_width_p-1:0] req_src_x_i,
  input  logic [y_cord_width_p-1:0] req_src_y_i,
  input  logic [reg_id_width_p-1:0] req_reg_id_i,
  output logic                      resp_v_o,
  input  logic                      resp_ready_i,
  output logic [1:0]                resp_type_o,
  output logic [data_width_p-1:0]   resp_data_o,
  output logic [reg_id_width_p-1:0] resp_reg_id_o,
  output logic [x_cord_width_p-1:0] resp_dst_x_o,
  output logic [y_cord_width_p-1:0] resp_dst_y_o,
  output logic                      err_o,
  output logic [31:0]               req_count_o
);

  localparam int unsigned MaskW = data_width_p / 8;
  localparam int unsigned IdxW  = $clog2(els_p);

  localparam logic [1:0] OpLoad  = 2'd0;
  localparam logic [1:0] OpStore = 2'd1;
  localparam logic [1:0] OpSwap  = 2'd2;
  localparam logic [1:0] OpRsvd  = 2'd3;
  localparam logic [1:0] RespErr = 2'd3;

  typedef struct packed {
    logic [1:0]                typ;
    logic [reg_id_width_p-1:0] id;
    logic [x_cord_width_p-1:0] x;
    logic [y_cord_width_p-1:0] y;
  } meta_t;

  typedef struct packed {
    meta_t                   meta;
    logic [data_width_p-1:0] data;
  } resp_t;

  logic                    accept, deq, in_range, is_err, rd_en, wr_en;
  logic [MaskW-1:0]        wr_mask;
  logic [IdxW-1:0]         idx;
  logic [data_width_p-1:0] mem_q [els_p];
  logic [data_width_p-1:0] rdata_q;

  logic        infl_v_q, infl_v_d;
  meta_t       infl_q, infl_d;
  resp_t       new_entry;
  resp_t       fifo_q [2];
  resp_t       fifo_d [2];
  logic [1:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] count_q, count_d;

  // Occupancy of stage + FIFO never exceeds 2, so the stage can always drain.
  assign req_ready_o = ({1'b0, cnt_q} + {2'b00, infl_v_q}) < 3'd2;
  assign accept      = req_v_i & req_ready_o;
  assign deq         = resp_v_o & resp_ready_i;

  assign in_range = req_addr_i < addr_width_p'(els_p);
  assign is_err   = (req_op_i == OpRsvd) | ~in_range;
  assign idx      = req_addr_i[IdxW-1:0];
  assign rd_en    = accept & in_range;
  assign wr_en    = accept & ~is_err & ((req_op_i == OpStore) | (req_op_i == OpSwap));
  assign wr_mask  = (req_op_i == OpSwap) ? {MaskW{1'b1}} : req_mask_i;

  // Read-before-write SRAM; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (rd_en) rdata_q <= mem_q[idx];
    for (int b = 0; b < int'(MaskW); b++) begin
      if (wr_en && wr_mask[b]) mem_q[idx][b*8 +: 8] <= req_data_i[b*8 +: 8];
    end
  end

  always_comb begin
    infl_v_d = accept;
    infl_d   = infl_q;
    err_d    = err_q | (accept & is_err);
    count_d  = accept ? count_q + 32'd1 : count_q;
    if (accept) begin
      infl_d.typ = is_err ? RespErr : req_op_i;
      infl_d.id  = req_reg_id_i;
      infl_d.x   = req_src_x_i;
      infl_d.y   = req_src_y_i;
    end

    new_entry.meta = infl_q;
    new_entry.data = ((infl_q.typ == OpLoad) || (infl_q.typ == OpSwap)) ? rdata_q : '0;

    // Shift-style FIFO: slot 0 is always the head driving the outputs.
    fifo_d[0] = fifo_q[0];
    fifo_d[1] = fifo_q[1];
    cnt_d     = cnt_q;
    if (deq) begin
      fifo_d[0] = fifo_q[1];
      cnt_d     = cnt_q - 2'd1;
    end
    if (infl_v_q) begin
      fifo_d[cnt_d[0]] = new_entry;
      cnt_d            = cnt_d + 2'd1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      infl_v_q  <= 1'b0;
      infl_q    <= '0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      cnt_q     <= 2'd0;
      err_q     <= 1'b0;
      count_q   <= 32'd0;
    end else begin
      infl_v_q  <= infl_v_d;
      infl_q    <= infl_d;
      fifo_q[0] <= fifo_d[0];
      fifo_q[1] <= fifo_d[1];
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      count_q   <= count_d;
    end
  end

  assign resp_v_o      = cnt_q != 2'd0;
  assign resp_type_o   = fifo_q[0].meta.typ;
  assign resp_data_o   = fifo_q[0].data;
  assign resp_reg_id_o = fifo_q[0].meta.id;
  assign resp_dst_x_o  = fifo_q[0].meta.x;
  assign resp_dst_y_o  = fifo_q[0].meta.y;
  assign err_o         = err_q;
  assign req_count_o   = count_q;

endmodule

// File: tb/tb_manycore_ep_mem_responder.sv
// Scoreboard bench for manycore_ep_mem_responder: a reference memory model
// predicts each response at acceptance; the monitor compares at consumption.
module tb_manycore_ep_mem_responder;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        req_v_i = 1'b0;
  logic        req_ready_o;
  logic [1:0]  req_op_i = '0;
  logic [27:0] req_addr_i = '0;
  logic [31:0] req_data_i = '0;
  logic [3:0]  req_mask_i = '0;
  logic [6:0]  req_src_x_i = '0;
  logic [6:0]  req_src_y_i = '0;
  logic [4:0]  req_reg_id_i = '0;
  logic        resp_v_o;
  logic        resp_ready_i = 1'b1;
  logic [1:0]  resp_type_o;
  logic [31:0] resp_data_o;
  logic [4:0]  resp_reg_id_o;
  logic [6:0]  resp_dst_x_o;
  logic [6:0]  resp_dst_y_o;
  logic        err_o;
  logic [31:0] req_count_o;

  manycore_ep_mem_responder dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_v_i(req_v_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_mask_i(req_mask_i),
    .req_src_x_i(req_src_x_i), .req_src_y_i(req_src_y_i), .req_reg_id_i(req_reg_id_i),
    .resp_v_o(resp_v_o), .resp_ready_i(resp_ready_i), .resp_type_o(resp_type_o),
    .resp_data_o(resp_data_o), .resp_reg_id_o(resp_reg_id_o),
    .resp_dst_x_o(resp_dst_x_o), .resp_dst_y_o(resp_dst_y_o),
    .err_o(err_o), .req_count_o(req_count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  typ;
    logic [31:0] data;
    logic [4:0]  id;
    logic [6:0]  x;
    logic [6:0]  y;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mm [0:1023];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [27:0] addr, input logic [31:0] data,
                      input logic [3:0] mask, input logic [6:0] x, input logic [6:0] y,
                      input logic [4:0] id);
    exp_t e;
    int   n = 0;
    req_v_i = 1'b1; req_op_i = op; req_addr_i = addr; req_data_i = data;
    req_mask_i = mask; req_src_x_i = x; req_src_y_i = y; req_reg_id_i = id;
    @(negedge clk_i);
    while (!req_ready_o && n < 60) begin
      @(negedge clk_i);
      n++;
    end
    if (!req_ready_o) begin
      check("req_accept_timeout", 32'd1, 32'd0);
    end else begin
      e.id = id; e.x = x; e.y = y; e.data = 32'd0;
      if (op == 2'd3 || addr >= 28'd1024) begin
        e.typ = 2'd3;
      end else begin
        e.typ = op;
        case (op)
          2'd0: e.data = mm[addr[9:0]];
          2'd1: for (int b = 0; b < 4; b++)
                  if (mask[b]) mm[addr[9:0]][b*8 +: 8] = data[b*8 +: 8];
          default: begin
            e.data = mm[addr[9:0]];
            mm[addr[9:0]] = data;
          end
        endcase
      end
      exp_q.push_back(e);
    end
    @(posedge clk_i);
    #1 req_v_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse_reset();
    @(posedge clk_i);
    #3 reset_i = 1'b1;
    #1;
    check("rst_resp_v", 32'(resp_v_o), 32'd0);
    check("rst_ready", 32'(req_ready_o), 32'd1);
    check("rst_count", req_count_o, 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_resp_data", resp_data_o, 32'd0);
    exp_q.delete();
    #1 reset_i = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: a response shown at the falling edge is consumed at the next rising edge.
  always @(negedge clk_i) begin
    exp_t e;
    if (!reset_i && resp_v_o && resp_ready_i) begin
      if (exp_q.size() == 0) begin
        check("resp_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("resp_type", 32'(resp_type_o), 32'(e.typ));
        check("resp_data", resp_data_o, e.data);
        check("resp_id", 32'(resp_reg_id_o), 32'(e.id));
        check("resp_dst_x", 32'(resp_dst_x_o), 32'(e.x));
        check("resp_dst_y", 32'(resp_dst_y_o), 32'(e.y));
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk_i);
    #1 reset_i = 1'b0;
    @(negedge clk_i);
    check("init_ready", 32'(req_ready_o), 32'd1);
    check("init_resp_v", 32'(resp_v_o), 32'd0);
    check("init_err", 32'(err_o), 32'd0);
    check("init_count", req_count_o, 32'd0);
    @(posedge clk_i);
    #1;

    // Store then back-to-back load (read-after-write)
    send(2'd1, 28'd5, 32'hDEADBEEF, 4'hF, 7'd3, 7'd2, 5'd7);
    send(2'd0, 28'd5, 32'h0, 4'h0, 7'd3, 7'd2, 5'd8);
    // Byte mask merge
    send(2'd1, 28'd9, 32'h11223344, 4'hF, 7'd1, 7'd1, 5'd1);
    send(2'd1, 28'd9, 32'hAABBCCDD, 4'h5, 7'd1, 7'd1, 5'd2);
    send(2'd0, 28'd9, 32'h0, 4'h0, 7'd1, 7'd1, 5'd3);
    // Swap, mask ignored
    send(2'd1, 28'd12, 32'h5, 4'hF, 7'd4, 7'd6, 5'd4);
    send(2'd2, 28'd12, 32'h9, 4'h0, 7'd4, 7'd6, 5'd5);
    send(2'd0, 28'd12, 32'h0, 4'h0, 7'd4, 7'd6, 5'd6);
    drain("drain_basic");
    check("count_basic", req_count_o, 32'd8);
    check("err_clean", 32'(err_o), 32'd0);

    // Backpressure: only two requests fit in stage + FIFO
    pulse_reset();
    resp_ready_i = 1'b0;
    fork
      begin
        send(2'd1, 28'd20, 32'hCAFE0001, 4'hF, 7'd9, 7'd8, 5'd21);
        send(2'd0, 28'd20, 32'h0, 4'h0, 7'd9, 7'd8, 5'd22);
        send(2'd1, 28'd21, 32'h0BAD0002, 4'hF, 7'd9, 7'd8, 5'd23);
        send(2'd0, 28'd21, 32'h0, 4'h0, 7'd9, 7'd8, 5'd24);
      end
      begin
        repeat (6) @(negedge clk_i);
        check("bp_ready_low", 32'(req_ready_o), 32'd0);
        check("bp_count2", req_count_o, 32'd2);
        check("bp_valid", 32'(resp_v_o), 32'd1);
        check("bp_hold_id", 32'(resp_reg_id_o), 32'd21);
        repeat (4) @(negedge clk_i);
        check("bp_hold_id_late", 32'(resp_reg_id_o), 32'd21);
        check("bp_hold_type_late", 32'(resp_type_o), 32'd1);
        check("bp_hold_data_late", resp_data_o, 32'd0);
        @(posedge clk_i);
        #1 resp_ready_i = 1'b1;
      end
    join
    drain("drain_bp");
    check("bp_count4", req_count_o, 32'd4);

    // Errors: out-of-range address and reserved op
    @(posedge clk_i);
    #1;
    send(2'd0, 28'd1024, 32'h0, 4'h0, 7'd2, 7'd5, 5'd30);
    check("err_set_at_accept", 32'(err_o), 32'd1);
    send(2'd3, 28'd5, 32'h12345678, 4'hF, 7'd2, 7'd5, 5'd31);
    drain("drain_err");
    check("err_after", 32'(err_o), 32'd1);
    repeat (100) @(negedge clk_i);
    check("err_sticky", 32'(err_o), 32'd1);
    check("err_count", req_count_o, 32'd6);

    // Reset with two responses pending; SRAM contents survive
    resp_ready_i = 1'b0;
    @(posedge clk_i);
    #1;
    send(2'd0, 28'd5, 32'h0, 4'h0, 7'd3, 7'd2, 5'd10);
    send(2'd0, 28'd9, 32'h0, 4'h0, 7'd3, 7'd2, 5'd11);
    repeat (2) @(negedge clk_i);
    check("pre_rst_valid", 32'(resp_v_o), 32'd1);
    pulse_reset();
    resp_ready_i = 1'b1;
    send(2'd0, 28'd5, 32'h0, 4'h0, 7'd3, 7'd2, 5'd12);
    drain("drain_post_rst");
    check("post_rst_count", req_count_o, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
